branch_predict_unit: RTL

- Parametrised successor to the single-cycle branch resolver. Adds a direct-mapped BTB with 2-bit saturating BHT counters for fetch-stage prediction.
- Resolves branches and jumps in EX using the existing PC+Imm / PC+4 / taken rules, detects mispredictions and drives redirect.
- Trains the tables and counts branches and mispredictions.
- Sits between the fetch PC mux (lookup side) and the EX stage (resolve side).

---
 rtl/branch_predict_unit_pkg.sv | 56 +++++
 rtl/branch_predict_unit_if.sv | 44 ++++
 rtl/branch_predict_unit_btb_table.sv | 45 ++++
 rtl/branch_predict_unit.sv | 127 ++++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Shared types and helpers for the branch prediction unit.
//   bht_ctr_t   : 2-bit saturating direction counter
//   btb_entry_t : one BTB/BHT entry. The tag and target fields are sized for
//                 the widest PC. Narrower configurations zero-fill the upper
//                 bits, and synthesis trims them as constants.
//   sat_inc/sat_dec : saturating counter steps
//   idx_of/tag_of   : PC field extraction for a table of 2**idx_w entries
package branch_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_ctr_t;

  localparam int unsigned FIELD_W = 32;

  typedef struct packed {
    logic               valid;
    logic [FIELD_W-1:0] tag;
    logic [FIELD_W-1:0] target;
    logic               jmp;
    bht_ctr_t           ctr;
  } btb_entry_t;

  function automatic bht_ctr_t sat_inc(input bht_ctr_t c);
    bht_ctr_t r;
    case (c)
      SNT:     r = WNT;
      WNT:     r = WT;
      default: r = ST;
    endcase
    return r;
  endfunction

  function automatic bht_ctr_t sat_dec(input bht_ctr_t c);
    bht_ctr_t r;
    case (c)
      ST:      r = WT;
      WT:      r = WNT;
      default: r = SNT;
    endcase
    return r;
  endfunction

  // Word-aligned PCs: bits [1:0] take no part in indexing.
  function automatic logic [31:0] idx_of(input logic [31:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc, input int unsigned idx_w);
    return pc >> (idx_w + 32'd2);
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Bus between the pipeline and branch_predict_unit.
//   Lookup side : IF_PC -> Pred_Taken, Pred_Target
//   Resolve side: EX_Valid, EX_PC, Imm, Branch, Jump, AluResult,
//                 EX_Pred_Taken, EX_Pred_Target
//              -> PC_Imm, PC_Four, PcSel, Mispredict, Redirect_PC
//   Statistics  : Br_Count, Miss_Count
// The master modport belongs to the pipeline and the slave modport to the unit.
interface branch_predict_unit_if #(
  parameter int unsigned PC_W  = 9,
  parameter int unsigned CNT_W = 16
);
  logic [PC_W-1:0]  IF_PC;
  logic             Pred_Taken;
  logic [PC_W-1:0]  Pred_Target;
  logic             EX_Valid;
  logic [PC_W-1:0]  EX_PC;
  logic [31:0]      Imm;
  logic             Branch;
  logic             Jump;
  logic [31:0]      AluResult;
  logic             EX_Pred_Taken;
  logic [PC_W-1:0]  EX_Pred_Target;
  logic [31:0]      PC_Imm;
  logic [31:0]      PC_Four;
  logic             PcSel;
  logic             Mispredict;
  logic [31:0]      Redirect_PC;
  logic [CNT_W-1:0] Br_Count;
  logic [CNT_W-1:0] Miss_Count;

  modport master (
    output IF_PC, EX_Valid, EX_PC, Imm, Branch, Jump, AluResult,
           EX_Pred_Taken, EX_Pred_Target,
    input  Pred_Taken, Pred_Target, PC_Imm, PC_Four, PcSel, Mispredict,
           Redirect_PC, Br_Count, Miss_Count
  );

  modport slave (
    input  IF_PC, EX_Valid, EX_PC, Imm, Branch, Jump, AluResult,
           EX_Pred_Taken, EX_Pred_Target,
    output Pred_Taken, Pred_Target, PC_Imm, PC_Four, PcSel, Mispredict,
           Redirect_PC, Br_Count, Miss_Count
  );
endinterface

// File: rtl/branch_predict_unit_btb_table.sv
// Direct-mapped BTB/BHT storage.
//   rd_idx -> rd_entry : combinational lookup read (fetch side)
//   ex_idx -> ex_entry : combinational read of the entry being trained (EX side)
//   wr_en/wr_idx/wr_entry : synchronous whole-entry write
//   inv_en             : synchronous clear of valid at wr_idx
// An asynchronous reset clears every valid bit and sets every counter to weakly
// not-taken. Reads return the contents from before the write (no bypass).
module btb_table
  import branch_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output btb_entry_t       rd_entry,
  input  logic [IDX_W-1:0] ex_idx,
  output btb_entry_t       ex_entry,
  input  logic             wr_en,
  input  logic             inv_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_entry
);

  btb_entry_t mem [ENTRIES];

  always_comb begin
    rd_entry = mem[rd_idx];
    ex_entry = mem[ex_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        mem[IDX_W'(i)] <= '{valid: 1'b0, tag: '0, target: '0, jmp: 1'b0, ctr: WNT};
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_entry;
    end else if (inv_en) begin
      mem[wr_idx].valid <= 1'b0;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction and resolution unit.
//   clk, reset : rising-edge clock and asynchronous active-high reset
//   bus        : pipeline bus (slave side). It carries the fetch lookup
//                (IF_PC -> Pred_Taken/Pred_Target), the EX resolve inputs and
//                outputs (PC_Imm, PC_Four, PcSel, Mispredict, Redirect_PC),
//                and the saturating counters Br_Count and Miss_Count.
// The lookup is combinational. Training takes place on the rising edge
// whenever EX holds a live instruction.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int unsigned PC_W    = 9,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 16
) (
  input logic                  clk,
  input logic                  reset,
  branch_predict_unit_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - 2 - IDX_W;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  btb_entry_t       rd_entry, ex_entry, wr_entry;
  logic             wr_en, inv_en;
  logic             if_hit, pred_taken, ex_hit;
  logic             taken, ctl, mispredict;
  logic [31:0]      pc_imm, pc_four;
  logic [CNT_W-1:0] br_count, miss_count;
  logic             unused_bits;

  // The second read port lets EX see whether its own PC hits while fetch looks up a different PC.
  btb_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk      (clk),
    .rst      (reset),
    .rd_idx   (if_idx),
    .rd_entry (rd_entry),
    .ex_idx   (ex_idx),
    .ex_entry (ex_entry),
    .wr_en    (wr_en),
    .inv_en   (inv_en),
    .wr_idx   (ex_idx),
    .wr_entry (wr_entry)
  );

  // Fetch-side lookup
  always_comb begin
    if_idx          = IDX_W'(idx_of(32'(bus.IF_PC), IDX_W));
    if_tag          = TAG_W'(tag_of(32'(bus.IF_PC), IDX_W));
    if_hit          = rd_entry.valid && (rd_entry.tag == 32'(if_tag));
    pred_taken      = if_hit && (rd_entry.jmp || rd_entry.ctr[1]);
    bus.Pred_Taken  = pred_taken;
    bus.Pred_Target = pred_taken ? rd_entry.target[PC_W-1:0] : bus.IF_PC + PC_W'(4);
  end

  // EX-side resolution
  always_comb begin
    pc_imm          = 32'(bus.EX_PC) + bus.Imm;
    pc_four         = 32'(bus.EX_PC) + 32'd4;
    taken           = (bus.Branch && bus.AluResult[0]) || bus.Jump;
    ctl             = bus.Branch || bus.Jump;
    mispredict      = bus.EX_Valid &&
                      ((bus.EX_Pred_Taken != taken) ||
                       (taken && (bus.EX_Pred_Target != pc_imm[PC_W-1:0])));
    bus.PC_Imm      = pc_imm;
    bus.PC_Four     = pc_four;
    bus.PcSel       = taken;
    bus.Mispredict  = mispredict;
    bus.Redirect_PC = taken ? pc_imm : pc_four;
  end

  // Training request for the EX instruction
  always_comb begin
    ex_idx   = IDX_W'(idx_of(32'(bus.EX_PC), IDX_W));
    ex_tag   = TAG_W'(tag_of(32'(bus.EX_PC), IDX_W));
    ex_hit   = ex_entry.valid && (ex_entry.tag == 32'(ex_tag));
    wr_en    = 1'b0;
    inv_en   = 1'b0;
    wr_entry = ex_entry;
    if (bus.EX_Valid) begin
      if (ctl) begin
        if (ex_hit && taken) begin
          wr_en           = 1'b1;
          wr_entry.ctr    = sat_inc(ex_entry.ctr);
          wr_entry.target = 32'(pc_imm[PC_W-1:0]);
          wr_entry.jmp    = bus.Jump;
        end else if (ex_hit) begin
          wr_en        = 1'b1;
          wr_entry.ctr = sat_dec(ex_entry.ctr);
        end else if (taken) begin
          wr_en    = 1'b1;
          wr_entry = '{valid: 1'b1, tag: 32'(ex_tag), target: 32'(pc_imm[PC_W-1:0]),
                       jmp: bus.Jump, ctr: WT};
        end
      end else if (bus.EX_Pred_Taken) begin
        // A predicted-taken non-control instruction means the entry is stale
        inv_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_count   <= '0;
      miss_count <= '0;
    end else begin
      if (bus.EX_Valid && ctl && !(&br_count)) begin
        br_count <= br_count + CNT_W'(1);
      end
      if (mispredict && !(&miss_count)) begin
        miss_count <= miss_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    bus.Br_Count   = br_count;
    bus.Miss_Count = miss_count;
    unused_bits    = ^{rd_entry.target[31:PC_W], rd_entry.ctr[0], bus.AluResult[31:1]};
  end

endmodule
